// File: rtl/core_ctrl_wb_arb.sv
// Round-robin writeback arbiter: NREQ one-entry result slots drained one per cycle
// into registered regfile-write / scoreboard-retire outputs. Optional macro CORE_WB_FWD_EN.
module core_ctrl_wb_arb #(
  parameter int NREQ = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd_idx,
  input  logic [XLEN*NREQ-1:0] req_data,
  output logic                 rf_wr_en,
  output logic [4:0]           rf_wr_idx,
  output logic [XLEN-1:0]      rf_wr_data,
  output logic                 scb_ret_reg_valid,
  output logic [4:0]           scb_ret_reg_idx,
  output logic [NREQ-1:0]      wb_pending,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_idx,
  output logic [XLEN-1:0]      fwd_data
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W:0]   NREQ_W = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREQ - 1);

  logic [NREQ-1:0] slot_valid_q, slot_valid_d;
  logic [4:0]      slot_idx_q  [NREQ];
  logic [4:0]      slot_idx_d  [NREQ];
  logic [XLEN-1:0] slot_data_q [NREQ];
  logic [XLEN-1:0] slot_data_d [NREQ];

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            rf_wr_en_q, rf_wr_en_d;
  logic [4:0]      rf_wr_idx_q, rf_wr_idx_d;
  logic [XLEN-1:0] rf_wr_data_q, rf_wr_data_d;
  logic            scb_valid_q, scb_valid_d;
  logic [4:0]      scb_idx_q, scb_idx_d;

  logic [NREQ-1:0]  grant;
  logic             gnt_any;
  logic [PTR_W-1:0] gnt_sel;
  logic [4:0]       gnt_idx;
  logic [XLEN-1:0]  gnt_data;

  // Scan slots starting at rr_ptr; the first occupied one wins.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    grant   = '0;
    gnt_any = 1'b0;
    gnt_sel = '0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      cand = sum[PTR_W-1:0];
      if (!gnt_any && slot_valid_q[cand]) begin
        gnt_any     = 1'b1;
        gnt_sel     = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  assign gnt_idx  = slot_idx_q[gnt_sel];
  assign gnt_data = slot_data_q[gnt_sel];

  // Ready depends only on slot state, so a draining slot can refill in the same cycle.
  assign req_ready  = ~slot_valid_q | grant;
  assign wb_pending = slot_valid_q;

  always_comb begin
    slot_valid_d = slot_valid_q;
    for (int i = 0; i < NREQ; i++) begin
      slot_idx_d[i]  = slot_idx_q[i];
      slot_data_d[i] = slot_data_q[i];
      if (req_valid[i] && req_ready[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_idx_d[i]   = req_rd_idx[5*i +: 5];
        slot_data_d[i]  = req_data[XLEN*i +: XLEN];
      end else if (grant[i]) begin
        slot_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_idx_d  = rf_wr_idx_q;
    rf_wr_data_d = rf_wr_data_q;
    scb_valid_d  = 1'b0;
    scb_idx_d    = scb_idx_q;
    if (gnt_any) begin
      rr_ptr_d     = (gnt_sel == LAST_PTR) ? '0 : gnt_sel + 1'b1;
      // x0 still retires to the scoreboard; only the regfile write is dropped.
      rf_wr_en_d   = (gnt_idx != 5'd0);
      rf_wr_idx_d  = gnt_idx;
      rf_wr_data_d = gnt_data;
      scb_valid_d  = 1'b1;
      scb_idx_d    = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slot_idx_q[i]  <= '0;
        slot_data_q[i] <= '0;
      end
      rr_ptr_q     <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_idx_q  <= '0;
      rf_wr_data_q <= '0;
      scb_valid_q  <= 1'b0;
      scb_idx_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      for (int i = 0; i < NREQ; i++) begin
        slot_idx_q[i]  <= slot_idx_d[i];
        slot_data_q[i] <= slot_data_d[i];
      end
      rr_ptr_q     <= rr_ptr_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_idx_q  <= rf_wr_idx_d;
      rf_wr_data_q <= rf_wr_data_d;
      scb_valid_q  <= scb_valid_d;
      scb_idx_q    <= scb_idx_d;
    end
  end

  assign rf_wr_en          = rf_wr_en_q;
  assign rf_wr_idx         = rf_wr_idx_q;
  assign rf_wr_data        = rf_wr_data_q;
  assign scb_ret_reg_valid = scb_valid_q;
  assign scb_ret_reg_idx   = scb_idx_q;

`ifdef CORE_WB_FWD_EN
  // Bypass shows the granted slot one cycle ahead of the registered write.
  logic fwd_hit;
  assign fwd_hit   = gnt_any & (gnt_idx != 5'd0);
  assign fwd_valid = fwd_hit;
  assign fwd_idx   = fwd_hit ? gnt_idx : 5'd0;
  assign fwd_data  = fwd_hit ? gnt_data : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_idx   = 5'd0;
  assign fwd_data  = '0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant));
  a_grant_valid:  assert property (@(posedge clk) disable iff (!rstn) (grant & ~slot_valid_q) == '0);

endmodule

// File: tb/tb_core_ctrl_wb_arb.sv
// Scoreboard bench for core_ctrl_wb_arb: a reference round-robin model pushes the
// expected writeback each cycle; the entry is popped and compared after the edge.
module tb_core_ctrl_wb_arb;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [5*NREQ-1:0]    req_rd_idx;
  logic [XLEN*NREQ-1:0] req_data;
  logic                 rf_wr_en;
  logic [4:0]           rf_wr_idx;
  logic [XLEN-1:0]      rf_wr_data;
  logic                 scb_ret_reg_valid;
  logic [4:0]           scb_ret_reg_idx;
  logic [NREQ-1:0]      wb_pending;
  logic                 fwd_valid;
  logic [4:0]           fwd_idx;
  logic [XLEN-1:0]      fwd_data;

  core_ctrl_wb_arb #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk               (clk),
    .rstn              (rstn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_rd_idx        (req_rd_idx),
    .req_data          (req_data),
    .rf_wr_en          (rf_wr_en),
    .rf_wr_idx         (rf_wr_idx),
    .rf_wr_data        (rf_wr_data),
    .scb_ret_reg_valid (scb_ret_reg_valid),
    .scb_ret_reg_idx   (scb_ret_reg_idx),
    .wb_pending        (wb_pending),
    .fwd_valid         (fwd_valid),
    .fwd_idx           (fwd_idx),
    .fwd_data          (fwd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic            valid;
    logic            en;
    logic [4:0]      idx;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [NREQ-1:0] m_valid;
  logic [4:0]      m_idx  [NREQ];
  logic [XLEN-1:0] m_data [NREQ];
  int              m_ptr;
  logic [4:0]      h_idx;
  logic [XLEN-1:0] h_data;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    m_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_idx[i]  = '0;
      m_data[i] = '0;
    end
    m_ptr  = 0;
    h_idx  = '0;
    h_data = '0;
    exp_q.delete();
  endtask

  // Called just after a negedge; returns just after the following negedge.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [5*NREQ-1:0] idx,
                               input logic [XLEN*NREQ-1:0] data);
    int              g;
    logic [NREQ-1:0] rdy;
    exp_t            e;
    logic            fv;
    logic [4:0]      fi;
    logic [XLEN-1:0] fd;
    req_valid  = v;
    req_rd_idx = idx;
    req_data   = data;
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (g < 0 && m_valid[c]) g = c;
    end
    rdy = ~m_valid;
    if (g >= 0) rdy[g] = 1'b1;
    checkOutput("req_ready", 64'(req_ready), 64'(rdy));
    checkOutput("wb_pending", 64'(wb_pending), 64'(m_valid));
    fv = 1'b0;
    fi = '0;
    fd = '0;
`ifdef CORE_WB_FWD_EN
    if (g >= 0 && m_idx[g] != 5'd0) begin
      fv = 1'b1;
      fi = m_idx[g];
      fd = m_data[g];
    end
`endif
    checkOutput("fwd_valid", 64'(fwd_valid), 64'(fv));
    checkOutput("fwd_idx", 64'(fwd_idx), 64'(fi));
    checkOutput("fwd_data", 64'(fwd_data), 64'(fd));
    if (g >= 0) begin
      e.valid = 1'b1;
      e.en    = (m_idx[g] != 5'd0);
      e.idx   = m_idx[g];
      e.data  = m_data[g];
      h_idx   = m_idx[g];
      h_data  = m_data[g];
      m_ptr   = (g + 1) % NREQ;
    end else begin
      e.valid = 1'b0;
      e.en    = 1'b0;
      e.idx   = h_idx;
      e.data  = h_data;
    end
    exp_q.push_back(e);
    for (int i = 0; i < NREQ; i++) begin
      if (v[i] && rdy[i]) begin
        m_valid[i] = 1'b1;
        m_idx[i]   = idx[5*i +: 5];
        m_data[i]  = data[XLEN*i +: XLEN];
      end else if (g == i) begin
        m_valid[i] = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    checkOutput("rf_wr_en", 64'(rf_wr_en), 64'(e.en));
    checkOutput("rf_wr_idx", 64'(rf_wr_idx), 64'(e.idx));
    checkOutput("rf_wr_data", 64'(rf_wr_data), 64'(e.data));
    checkOutput("scb_valid", 64'(scb_ret_reg_valid), 64'(e.valid));
    checkOutput("scb_idx", 64'(scb_ret_reg_idx), 64'(e.idx));
  endtask

  task automatic sendOne(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
    logic [NREQ-1:0]      v;
    logic [5*NREQ-1:0]    iv;
    logic [XLEN*NREQ-1:0] dv;
    v  = '0;
    iv = '0;
    dv = '0;
    v[i]            = 1'b1;
    iv[5*i +: 5]    = rd;
    dv[XLEN*i +: XLEN] = d;
    applyStimulus(v, iv, dv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus('0, '0, '0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rf_wr_en"}, 64'(rf_wr_en), 64'(0));
    checkOutput({tag, "_rf_wr_idx"}, 64'(rf_wr_idx), 64'(0));
    checkOutput({tag, "_rf_wr_data"}, 64'(rf_wr_data), 64'(0));
    checkOutput({tag, "_scb_valid"}, 64'(scb_ret_reg_valid), 64'(0));
    checkOutput({tag, "_scb_idx"}, 64'(scb_ret_reg_idx), 64'(0));
    checkOutput({tag, "_wb_pending"}, 64'(wb_pending), 64'(0));
    checkOutput({tag, "_req_ready"}, 64'(req_ready), 64'({NREQ{1'b1}}));
    checkOutput({tag, "_fwd_valid"}, 64'(fwd_valid), 64'(0));
  endtask

  initial begin
    int              cnt [NREQ];
    int              nret;
    logic [7:0]      rid;
    logic [NREQ-1:0] rv;
    logic [5*NREQ-1:0]    ri;
    logic [XLEN*NREQ-1:0] rd;

    rstn       = 1'b0;
    req_valid  = '0;
    req_rd_idx = '0;
    req_data   = '0;
    resetModel();
    #3;
    checkResetState("reset");
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] single requester latency");
    sendOne(0, 5'd5, 32'hDEADBEEF);
    idle(3);

    $display("[TB] three requesters same cycle");
    applyStimulus(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333_0003, 32'h2222_0002, 32'h1111_0001});
    idle(4);
    applyStimulus(3'b101, {5'd9, 5'd0, 5'd8}, {32'hC, 32'h0, 32'hA});
    idle(3);

    $display("[TB] x0 retire");
    sendOne(1, 5'd0, 32'h1234);
    idle(3);

    $display("[TB] forwarding channel");
    sendOne(2, 5'd7, 32'hA5);
    idle(3);

    $display("[TB] random traffic");
    for (int c = 0; c < 40; c++) begin
      rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      ri = 15'($urandom);
      rd = {$urandom, $urandom, $urandom};
      applyStimulus(rv, ri, rd);
    end
    idle(4);

    $display("[TB] async reset with slots full");
    applyStimulus(3'b111, {5'd13, 5'd12, 5'd11}, {32'hBB, 32'hAA, 32'h99});
    applyStimulus('0, '0, '0);
    req_valid = '0;
    #2 rstn = 1'b0;
    #1 checkResetState("midreset");
    #1 rstn = 1'b1;
    resetModel();
    @(negedge clk);
    idle(4);

    $display("[TB] saturated fairness");
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    nret = 0;
    for (int c = 0; c < 34; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        ri[5*i +: 5]       = 5'(i + 1);
        rd[XLEN*i +: XLEN] = {8'(i), 24'(c)};
      end
      applyStimulus(3'b111, ri, rd);
      if (scb_ret_reg_valid && nret < 30) begin
        rid = rf_wr_data[31:24];
        checkOutput("rotation", 64'(rid), 64'(nret % NREQ));
        if (rid < NREQ) cnt[rid]++;
        nret++;
      end
    end
    for (int i = 0; i < NREQ; i++) checkOutput("fair_count", 64'(cnt[i]), 64'(10));
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
